mul_booth_seq: RTL and testbench



---
 rtl/mul_booth_seq_pkg.sv | 13 +
 rtl/booth_r4_sel.sv | 33 +++
 rtl/mul_booth_seq.sv | 105 ++++++++++
 tb/tb_mul_booth_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mul_booth_seq_pkg.sv
// mul_pkg: shared types and helpers for the iterative radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [2:0] {BZERO, BP1, BP2, BM1, BM2} booth_digit_t;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Radix-4 digits needed to cover a WIDTH-bit operand extended by two bits.
    function automatic int iter_of(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// booth_r4_sel: recodes one Booth triplet and selects the unsigned-shifted partial product.
module booth_r4_sel
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]         i_triplet,
    input  logic [WIDTH+1:0]   i_a_ext,
    output logic [2*WIDTH+1:0] o_pp,
    output logic               o_neg
);

    booth_digit_t       w_digit;
    logic [2*WIDTH+1:0] w_a_sx;

    always_comb begin
        w_digit = BZERO;
        case (i_triplet)
            3'b001, 3'b010: w_digit = BP1;
            3'b011:         w_digit = BP2;
            3'b100:         w_digit = BM2;
            3'b101, 3'b110: w_digit = BM1;
            default:        w_digit = BZERO;
        endcase
    end

    assign w_a_sx = {{WIDTH{i_a_ext[WIDTH+1]}}, i_a_ext};
    assign o_pp   = (w_digit == BP1 || w_digit == BM1) ? w_a_sx :
                    (w_digit == BP2 || w_digit == BM2) ? (w_a_sx << 1) : '0;
    // Negation is applied by the caller after shifting: invert plus carry-in.
    assign o_neg  = (w_digit == BM1 || w_digit == BM2);

endmodule

// File: rtl/mul_booth_seq.sv
// mul_booth_seq: iterative radix-4 Booth multiplier, one digit per cycle,
// signed/unsigned per operation, valid/ready on both sides.
module mul_booth_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int ITER = iter_of(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int PW   = 2 * WIDTH + 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t               r_state;
    logic [EW-1:0]        r_a;
    logic [EW:0]          r_b;
    logic [PW-1:0]        r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [2*WIDTH-1:0]   r_z;

    logic [EW-1:0]        w_a_ext;
    logic [EW-1:0]        w_b_ext;
    logic [PW-1:0]        w_pp;
    logic                 w_neg;
    logic [PW-1:0]        w_pp_sh;
    logic [PW-1:0]        w_acc_nxt;

    assign w_a_ext = {{2{is_signed & a[WIDTH-1]}}, a};
    assign w_b_ext = {{2{is_signed & b[WIDTH-1]}}, b};

    booth_r4_sel #(.WIDTH(WIDTH)) u_sel (
        .i_triplet (r_b[2:0]),
        .i_a_ext   (r_a),
        .o_pp      (w_pp),
        .o_neg     (w_neg)
    );

    assign w_pp_sh   = w_pp << {r_cnt, 1'b0};
    assign w_acc_nxt = r_acc + (w_neg ? ~w_pp_sh : w_pp_sh) + PW'(w_neg);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_z         <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_a        <= w_a_ext;
                    r_b        <= {w_b_ext, 1'b0};
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= CALC;
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_b   <= {2'b00, r_b[EW:2]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_z         <= w_acc_nxt[2*WIDTH-1:0];
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign z         = r_z;

endmodule

// File: tb/tb_mul_booth_seq.sv
// tb_mul_booth_seq: directed WIDTH=8 checks and randomized WIDTH=16 checks against an arithmetic model.
module tb_mul_booth_seq;

    localparam int LIM = 60000;

    logic        clk = 1'b0;
    logic        rst8 = 1'b1, iv8 = 1'b0, s8 = 1'b0, or8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ir8, ov8, busy8;
    logic [15:0] z8;

    logic        rst16 = 1'b1, iv16 = 1'b0, s16 = 1'b0, or16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ir16, ov16, busy16;
    logic [31:0] z16;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mul_booth_seq #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .z(z8), .busy(busy8)
    );

    mul_booth_seq #(.WIDTH(16)) d16 (
        .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .z(z16), .busy(busy16)
    );

    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
        longint x = longint'(a);
        longint y = longint'(b);
        longint p;
        if (s && a[w-1]) x -= (longint'(1) << w);
        if (s && b[w-1]) y -= (longint'(1) << w);
        p = x * y;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp, input string tag);
        int n = 0;
        int bc = 0;
        while (!ir8 && n < 20) begin tick(); n++; end
        check({tag, ".in_ready"}, 64'(ir8), 64'd1);
        a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < 20) begin
            if (busy8) bc++;
            tick();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'd5);
        check({tag, ".busy_cycles"}, 64'(bc), 64'd5);
        check({tag, ".z"}, 64'(z8), 64'(exp));
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, ".out_valid_clear"}, 64'(ov8), 64'd0);
    endtask

    initial begin
        int n;
        int rx;
        logic [15:0] e4;
        repeat (3) tick();
        check("reset.in_ready", 64'(ir8), 64'd1);
        check("reset.out_valid", 64'(ov8), 64'd0);
        check("reset.busy", 64'(busy8), 64'd0);
        check("reset.z", 64'(z8), 64'd0);
        rst8 = 1'b0; rst16 = 1'b0;
        tick();
        check("post_reset.in_ready", 64'(ir8), 64'd1);

        op8(8'h80, 8'h80, 1'b1, 16'h4000, "min_x_min");
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "ff_ff_u");
        op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "ff_ff_s");
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, "max_x_min");
        op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "m1_x_1");
        op8(8'h00, 8'h80, 1'b1, 16'h0000, "zero_x_min");

        // Backpressure: result held, new operands refused while DONE.
        e4 = 16'(ref_mul(8, 32'h12, 32'h34, 1'b0));
        a8 = 8'h12; b8 = 8'h34; s8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 20) begin tick(); n++; end
        check("bp.latency", 64'(n), 64'd5);
        for (int k = 0; k < 10; k++) begin
            iv8 = 1'(k % 2); a8 = 8'($urandom); b8 = 8'($urandom);
            tick();
            check("bp.out_valid", 64'(ov8), 64'd1);
            check("bp.z", 64'(z8), 64'(e4));
            check("bp.in_ready", 64'(ir8), 64'd0);
        end
        iv8 = 1'b0; or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("bp.release_out_valid", 64'(ov8), 64'd0);
        check("bp.release_in_ready", 64'(ir8), 64'd1);
        tick();
        check("bp.no_extra_op", 64'({ov8, busy8}), 64'd0);

        // Reset in the middle of a calculation discards it.
        a8 = 8'h55; b8 = 8'h66; s8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("abort.out_valid", 64'(ov8), 64'd0);
        check("abort.z", 64'(z8), 64'd0);
        check("abort.in_ready", 64'(ir8), 64'd1);
        check("abort.busy", 64'(busy8), 64'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (ov8) n++;
            tick();
        end
        check("abort.never_presented", 64'(n), 64'd0);
        op8(8'd3, 8'd5, 1'b0, 16'd15, "after_abort");

        // Randomized WIDTH=16 traffic with gaps and backpressure.
        rx = 0;
        fork
            begin
                for (int i = 0; i < 2000 && cyc < LIM; i++) begin
                    bit got;
                    repeat ($urandom_range(0, 3)) tick();
                    a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
                    iv16 = 1'b1;
                    do begin
                        got = ir16;
                        tick();
                    end while (!got && cyc < LIM);
                    iv16 = 1'b0;
                    if (got) q.push_back(ref_mul(16, 32'(a16), 32'(b16), s16));
                end
            end
            begin
                while (rx < 2000 && cyc < LIM) begin
                    bit fire;
                    or16 = ($urandom_range(0, 2) != 0);
                    fire = ov16 && or16;
                    tick();
                    if (fire) begin
                        if (q.size() == 0) check("rand.unexpected_result", 64'd1, 64'd0);
                        else check("rand.z", 64'(z16), q.pop_front());
                        rx++;
                    end
                end
                or16 = 1'b0;
            end
        join
        check("rand.received", 64'(rx), 64'd2000);
        check("rand.outstanding", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
